// File: rtl/display_pkg.sv
// Shared definitions for the display controller SPI front end:
// command opcodes and the frame parser state encoding.
package display_pkg;

   localparam logic [7:0] OP_NOP       = 8'h00;
   localparam logic [7:0] OP_FB_WRITE  = 8'h01;
   localparam logic [7:0] OP_REG_WRITE = 8'h02;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ADDR_HI,
      ST_ADDR_LO,
      ST_DATA,
      ST_DISCARD
   } state_e;

   function automatic logic opcode_valid(input logic [7:0] op);
      return (op == OP_NOP) || (op == OP_FB_WRITE) || (op == OP_REG_WRITE);
   endfunction

endpackage

// File: rtl/spi_frame_decoder.sv
// Parses SPI transactions into command frames (opcode, 16-bit address,
// payload) and issues framebuffer or control-register writes, tracking
// completed frames and error events.
module spi_frame_decoder
   import display_pkg::*;
#(
   parameter int unsigned FB_ADDR_W = 11
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [7:0]           rx_data,
   input  logic                 rx_valid,
   input  logic                 rx_sot,
   input  logic                 rx_eot,
   output logic [FB_ADDR_W-1:0] fb_addr,
   output logic [7:0]           fb_data,
   output logic                 fb_we,
   input  logic                 fb_ready,
   output logic [7:0]           reg_addr,
   output logic [7:0]           reg_data,
   output logic                 reg_we,
   output logic                 busy,
   output logic [15:0]          frame_count,
   output logic [7:0]           err_count
);

   state_e                 state_q, state_d;
   logic [7:0]             opcode_q, opcode_d;
   logic [7:0]             addr_hi_q, addr_hi_d;
   logic [7:0]             addr_lo_q, addr_lo_d;
   logic [FB_ADDR_W-1:0]   ptr_q, ptr_d;
   logic [FB_ADDR_W-1:0]   fb_addr_q, fb_addr_d;
   logic [7:0]             fb_data_q, fb_data_d;
   logic                   fb_we_q, fb_we_d;
   logic [7:0]             reg_addr_q, reg_addr_d;
   logic [7:0]             reg_data_q, reg_data_d;
   logic                   reg_we_q, reg_we_d;
   logic                   reg_done_q, reg_done_d;
   logic                   frame_err_q, frame_err_d;
   logic                   busy_q, busy_d;
   logic [15:0]            frame_count_q;
   logic [7:0]             err_count_q;
   logic                   err_ev;
   logic                   done_ev;

   // Next-state decode: the incoming byte is applied first, then rx_eot
   // closes the frame based on where that byte left the parser.
   always_comb begin
      state_d     = state_q;
      opcode_d    = opcode_q;
      addr_hi_d   = addr_hi_q;
      addr_lo_d   = addr_lo_q;
      ptr_d       = ptr_q;
      fb_addr_d   = fb_addr_q;
      fb_data_d   = fb_data_q;
      fb_we_d     = fb_we_q && !fb_ready;
      reg_addr_d  = reg_addr_q;
      reg_data_d  = reg_data_q;
      reg_we_d    = 1'b0;
      reg_done_d  = reg_done_q;
      frame_err_d = frame_err_q;
      err_ev      = 1'b0;
      done_ev     = 1'b0;

      if (rx_valid) begin
         if (rx_sot || state_q == ST_IDLE) begin
            // a start-of-transaction while a frame is still open means
            // the previous frame never saw its rx_eot
            if (rx_sot && state_q != ST_IDLE) begin
               err_ev = 1'b1;
            end
            opcode_d    = rx_data;
            frame_err_d = 1'b0;
            reg_done_d  = 1'b0;
            if (opcode_valid(rx_data)) begin
               state_d = ST_ADDR_HI;
            end else begin
               state_d     = ST_DISCARD;
               err_ev      = 1'b1;
               frame_err_d = 1'b1;
            end
         end else begin
            case (state_q)
               ST_ADDR_HI: begin
                  addr_hi_d = rx_data;
                  state_d   = ST_ADDR_LO;
               end
               ST_ADDR_LO: begin
                  addr_lo_d = rx_data;
                  ptr_d     = FB_ADDR_W'({addr_hi_q, rx_data});
                  state_d   = ST_DATA;
               end
               ST_DATA: begin
                  if (opcode_q == OP_FB_WRITE) begin
                     // overrun drops the byte but still advances the pointer
                     if (fb_we_q && !fb_ready) begin
                        err_ev      = 1'b1;
                        frame_err_d = 1'b1;
                     end else begin
                        fb_we_d   = 1'b1;
                        fb_addr_d = ptr_q;
                        fb_data_d = rx_data;
                     end
                     ptr_d = ptr_q + FB_ADDR_W'(1);
                  end else if (opcode_q == OP_REG_WRITE) begin
                     if (!reg_done_q) begin
                        reg_we_d   = 1'b1;
                        reg_addr_d = addr_lo_q;
                        reg_data_d = rx_data;
                        reg_done_d = 1'b1;
                     end else begin
                        err_ev      = 1'b1;
                        frame_err_d = 1'b1;
                        state_d     = ST_DISCARD;
                     end
                  end
               end
               default: ;
            endcase
         end
      end

      if (rx_eot) begin
         if (state_d == ST_DATA && !frame_err_d) begin
            done_ev = 1'b1;
         end
         if (state_d == ST_ADDR_HI || state_d == ST_ADDR_LO) begin
            err_ev = 1'b1;
         end
         state_d = ST_IDLE;
      end

      busy_d = (state_d != ST_IDLE) || fb_we_d;
   end

   // Parser state, write-port registers and status counters.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q       <= ST_IDLE;
         opcode_q      <= '0;
         addr_hi_q     <= '0;
         addr_lo_q     <= '0;
         ptr_q         <= '0;
         fb_addr_q     <= '0;
         fb_data_q     <= '0;
         fb_we_q       <= 1'b0;
         reg_addr_q    <= '0;
         reg_data_q    <= '0;
         reg_we_q      <= 1'b0;
         reg_done_q    <= 1'b0;
         frame_err_q   <= 1'b0;
         busy_q        <= 1'b0;
         frame_count_q <= '0;
         err_count_q   <= '0;
      end else begin
         state_q       <= state_d;
         opcode_q      <= opcode_d;
         addr_hi_q     <= addr_hi_d;
         addr_lo_q     <= addr_lo_d;
         ptr_q         <= ptr_d;
         fb_addr_q     <= fb_addr_d;
         fb_data_q     <= fb_data_d;
         fb_we_q       <= fb_we_d;
         reg_addr_q    <= reg_addr_d;
         reg_data_q    <= reg_data_d;
         reg_we_q      <= reg_we_d;
         reg_done_q    <= reg_done_d;
         frame_err_q   <= frame_err_d;
         busy_q        <= busy_d;
         frame_count_q <= frame_count_q + 16'(done_ev);
         if (err_ev && err_count_q != 8'hFF) begin
            err_count_q <= err_count_q + 8'd1;
         end
      end
   end

   assign fb_addr     = fb_addr_q;
   assign fb_data     = fb_data_q;
   assign fb_we       = fb_we_q;
   assign reg_addr    = reg_addr_q;
   assign reg_data    = reg_data_q;
   assign reg_we      = reg_we_q;
   assign busy        = busy_q;
   assign frame_count = frame_count_q;
   assign err_count   = err_count_q;

endmodule

// File: tb/tb_spi_frame_decoder.sv
// Self-checking bench for spi_frame_decoder: directed scenarios plus
// randomized frames checked against a frame-level reference model.
module tb_spi_frame_decoder;

   localparam int unsigned AW = 11;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic [7:0]    rx_data = '0;
   logic          rx_valid = 1'b0;
   logic          rx_sot = 1'b0;
   logic          rx_eot = 1'b0;
   logic [AW-1:0] fb_addr;
   logic [7:0]    fb_data;
   logic          fb_we;
   logic          fb_ready = 1'b1;
   logic [7:0]    reg_addr;
   logic [7:0]    reg_data;
   logic          reg_we;
   logic          busy;
   logic [15:0]   frame_count;
   logic [7:0]    err_count;

   spi_frame_decoder #(.FB_ADDR_W(AW)) dut (
      .clk(clk), .rst(rst),
      .rx_data(rx_data), .rx_valid(rx_valid), .rx_sot(rx_sot), .rx_eot(rx_eot),
      .fb_addr(fb_addr), .fb_data(fb_data), .fb_we(fb_we), .fb_ready(fb_ready),
      .reg_addr(reg_addr), .reg_data(reg_data), .reg_we(reg_we),
      .busy(busy), .frame_count(frame_count), .err_count(err_count)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad = 0;
   int cyc = 0;
   int exp_frames = 0;
   int exp_errs = 0;

   logic [7:0]    tx_q[$];
   int            drv_cyc[$];
   logic [AW-1:0] obs_fa[$];
   logic [7:0]    obs_fd[$];
   int            obs_fc[$];
   logic [15:0]   obs_reg[$];
   logic [AW-1:0] exp_fa[$];
   logic [7:0]    exp_fd[$];
   logic [15:0]   exp_reg[$];

   always @(posedge clk) cyc <= cyc + 1;

   // record accepted framebuffer writes and register strobes mid-cycle
   always @(negedge clk) begin
      if (rst && fb_we && fb_ready) begin
         obs_fa.push_back(fb_addr);
         obs_fd.push_back(fb_data);
         obs_fc.push_back(cyc);
      end
      if (rst && reg_we) obs_reg.push_back({reg_addr, reg_data});
   end

   task automatic clear_obs();
      obs_fa.delete(); obs_fd.delete(); obs_fc.delete(); obs_reg.delete();
      exp_fa.delete(); exp_fd.delete(); exp_reg.delete();
   endtask

   task automatic bump_err();
      exp_errs = (exp_errs < 255) ? exp_errs + 1 : 255;
   endtask

   // drives tx_q on consecutive cycles; eot either with the last byte or after it
   task automatic drive_frame(input bit with_eot, input bit eot_last);
      drv_cyc.delete();
      foreach (tx_q[i]) begin
         @(posedge clk); #1;
         rx_valid = 1'b1;
         rx_data  = tx_q[i];
         rx_sot   = (i == 0);
         rx_eot   = with_eot && eot_last && (i == tx_q.size() - 1);
         drv_cyc.push_back(cyc);
      end
      @(posedge clk); #1;
      rx_valid = 1'b0; rx_sot = 1'b0; rx_eot = 1'b0;
      if (with_eot && !eot_last) begin
         rx_eot = 1'b1;
         @(posedge clk); #1;
         rx_eot = 1'b0;
      end
      repeat (3) @(posedge clk);
      #1;
   endtask

   // frame-level reference: outcome of one complete frame closed by rx_eot
   task automatic model_frame();
      int len;
      logic [15:0] a16;
      len = tx_q.size();
      if (tx_q[0] > 8'h02) bump_err();
      else if (len < 3) bump_err();
      else begin
         a16 = {tx_q[1], tx_q[2]};
         if (tx_q[0] == 8'h00) exp_frames++;
         else if (tx_q[0] == 8'h01) begin
            for (int i = 3; i < len; i++) begin
               exp_fa.push_back(AW'((int'(a16) + i - 3) % (1 << AW)));
               exp_fd.push_back(tx_q[i]);
            end
            exp_frames++;
         end else begin
            if (len >= 4) exp_reg.push_back({tx_q[2], tx_q[3]});
            if (len >= 5) bump_err();
            else exp_frames++;
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      total++;
      if ({fb_we, fb_addr, fb_data, reg_we, reg_addr, reg_data, busy, frame_count, err_count} !== '0) begin
         bad++;
         $display("FAIL reset_outputs: got we=%b a=%h d=%h rwe=%b ra=%h rd=%h busy=%b fc=%0d ec=%0d want all zero",
                  fb_we, fb_addr, fb_data, reg_we, reg_addr, reg_data, busy, frame_count, err_count);
      end
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      total++;
      if ({fb_we, busy, frame_count, err_count} !== '0) begin
         bad++;
         $display("FAIL reset_release: got we=%b busy=%b fc=%0d ec=%0d want 0", fb_we, busy, frame_count, err_count);
      end
   endtask

   task automatic test_fb_write();
      clear_obs();
      tx_q = '{8'h01, 8'h00, 8'h10, 8'hAA, 8'hBB};
      drive_frame(1, 0);
      exp_frames++;
      total++;
      if (obs_fa.size() != 2) begin
         bad++;
         $display("FAIL fb_write_count: got %0d want 2", obs_fa.size());
      end else begin
         total++;
         if (obs_fa[0] !== 11'h010 || obs_fd[0] !== 8'hAA) begin
            bad++;
            $display("FAIL fb_write0: got (%h,%h) want (010,aa)", obs_fa[0], obs_fd[0]);
         end
         total++;
         if (obs_fa[1] !== 11'h011 || obs_fd[1] !== 8'hBB) begin
            bad++;
            $display("FAIL fb_write1: got (%h,%h) want (011,bb)", obs_fa[1], obs_fd[1]);
         end
         total++;
         if (obs_fc[0] != drv_cyc[3] + 1 || obs_fc[1] != drv_cyc[4] + 1) begin
            bad++;
            $display("FAIL fb_latency: got cycles %0d,%0d want %0d,%0d", obs_fc[0], obs_fc[1], drv_cyc[3] + 1, drv_cyc[4] + 1);
         end
      end
      total++;
      if (fb_we !== 1'b0 || busy !== 1'b0) begin
         bad++;
         $display("FAIL fb_idle: got we=%b busy=%b want 0 0", fb_we, busy);
      end
      total++;
      if (frame_count !== 16'(exp_frames) || err_count !== 8'(exp_errs)) begin
         bad++;
         $display("FAIL fb_counters: got fc=%0d ec=%0d want fc=%0d ec=%0d", frame_count, err_count, exp_frames, exp_errs);
      end
   endtask

   task automatic test_reg_write();
      clear_obs();
      tx_q = '{8'h02, 8'h00, 8'h05, 8'h3C, 8'h77};
      drive_frame(1, 0);
      bump_err();
      total++;
      if (obs_reg.size() != 1) begin
         bad++;
         $display("FAIL reg_pulse_count: got %0d want 1", obs_reg.size());
      end else begin
         total++;
         if (obs_reg[0] !== 16'h053C) begin
            bad++;
            $display("FAIL reg_write: got %h want 053c", obs_reg[0]);
         end
      end
      total++;
      if (frame_count !== 16'(exp_frames) || err_count !== 8'(exp_errs) || obs_fa.size() != 0) begin
         bad++;
         $display("FAIL reg_counters: got fc=%0d ec=%0d fbw=%0d want fc=%0d ec=%0d fbw=0",
                  frame_count, err_count, obs_fa.size(), exp_frames, exp_errs);
      end
   endtask

   task automatic test_wrap();
      clear_obs();
      tx_q = '{8'h01, 8'h07, 8'hFF, 8'h5A, 8'hA5};
      drive_frame(1, 1);
      exp_frames++;
      total++;
      if (obs_fa.size() != 2) begin
         bad++;
         $display("FAIL wrap_count: got %0d want 2", obs_fa.size());
      end else if (obs_fa[0] !== 11'h7FF || obs_fd[0] !== 8'h5A || obs_fa[1] !== 11'h000 || obs_fd[1] !== 8'hA5) begin
         bad++;
         $display("FAIL wrap_writes: got (%h,%h),(%h,%h) want (7ff,5a),(000,a5)", obs_fa[0], obs_fd[0], obs_fa[1], obs_fd[1]);
      end
      total++;
      if (frame_count !== 16'(exp_frames) || err_count !== 8'(exp_errs)) begin
         bad++;
         $display("FAIL wrap_counters: got fc=%0d ec=%0d want fc=%0d ec=%0d", frame_count, err_count, exp_frames, exp_errs);
      end
   endtask

   task automatic test_backpressure();
      clear_obs();
      fb_ready = 1'b0;
      tx_q = '{8'h01, 8'h00, 8'h20, 8'h11, 8'h22};
      drive_frame(1, 0);
      bump_err();
      total++;
      if (fb_we !== 1'b1 || fb_data !== 8'h11 || fb_addr !== 11'h020 || busy !== 1'b1) begin
         bad++;
         $display("FAIL bp_hold: got we=%b a=%h d=%h busy=%b want 1 020 11 1", fb_we, fb_addr, fb_data, busy);
      end
      total++;
      if (err_count !== 8'(exp_errs) || frame_count !== 16'(exp_frames) || obs_fa.size() != 0) begin
         bad++;
         $display("FAIL bp_overrun: got ec=%0d fc=%0d acc=%0d want ec=%0d fc=%0d acc=0",
                  err_count, frame_count, obs_fa.size(), exp_errs, exp_frames);
      end
      fb_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      total++;
      if (obs_fa.size() != 1) begin
         bad++;
         $display("FAIL bp_complete_count: got %0d want 1", obs_fa.size());
      end else if (obs_fa[0] !== 11'h020 || obs_fd[0] !== 8'h11) begin
         bad++;
         $display("FAIL bp_complete: got (%h,%h) want (020,11)", obs_fa[0], obs_fd[0]);
      end
      total++;
      if (fb_we !== 1'b0 || busy !== 1'b0) begin
         bad++;
         $display("FAIL bp_release: got we=%b busy=%b want 0 0", fb_we, busy);
      end
   endtask

   task automatic test_bad_opcode();
      clear_obs();
      tx_q = '{8'h7E, 8'h01, 8'h02, 8'h03};
      drive_frame(1, 0);
      bump_err();
      tx_q = '{8'h00, 8'h12, 8'h34, 8'h55};
      drive_frame(1, 0);
      exp_frames++;
      total++;
      if (err_count !== 8'(exp_errs) || frame_count !== 16'(exp_frames) || obs_fa.size() != 0 || obs_reg.size() != 0) begin
         bad++;
         $display("FAIL bad_opcode: got ec=%0d fc=%0d fbw=%0d rw=%0d want ec=%0d fc=%0d 0 0",
                  err_count, frame_count, obs_fa.size(), obs_reg.size(), exp_errs, exp_frames);
      end
   endtask

   task automatic test_restart_truncate();
      clear_obs();
      tx_q = '{8'h01, 8'h00, 8'h30, 8'h99};
      drive_frame(0, 0);
      tx_q = '{8'h01, 8'h00, 8'h31, 8'h77};
      drive_frame(1, 1);
      bump_err();
      exp_frames++;
      total++;
      if (obs_fa.size() != 2) begin
         bad++;
         $display("FAIL restart_count: got %0d want 2", obs_fa.size());
      end else if (obs_fa[0] !== 11'h030 || obs_fd[0] !== 8'h99 || obs_fa[1] !== 11'h031 || obs_fd[1] !== 8'h77) begin
         bad++;
         $display("FAIL restart_writes: got (%h,%h),(%h,%h) want (030,99),(031,77)", obs_fa[0], obs_fd[0], obs_fa[1], obs_fd[1]);
      end
      total++;
      if (err_count !== 8'(exp_errs) || frame_count !== 16'(exp_frames)) begin
         bad++;
         $display("FAIL restart_counters: got ec=%0d fc=%0d want ec=%0d fc=%0d", err_count, frame_count, exp_errs, exp_frames);
      end
      tx_q = '{8'h02, 8'h00};
      drive_frame(1, 0);
      bump_err();
      total++;
      if (err_count !== 8'(exp_errs) || frame_count !== 16'(exp_frames)) begin
         bad++;
         $display("FAIL truncated: got ec=%0d fc=%0d want ec=%0d fc=%0d", err_count, frame_count, exp_errs, exp_frames);
      end
   endtask

   task automatic test_random();
      int r;
      int len;
      for (int f = 0; f < 40; f++) begin
         clear_obs();
         tx_q.delete();
         r = $urandom_range(0, 4);
         if (r <= 2) tx_q.push_back(8'(r));
         else if (r == 3) tx_q.push_back(8'($urandom_range(3, 255)));
         else tx_q.push_back(8'h01);
         len = $urandom_range(1, 7);
         for (int i = 1; i < len; i++) tx_q.push_back(8'($urandom));
         model_frame();
         drive_frame(1, 1'($urandom));
         total++;
         if (obs_fa.size() != exp_fa.size() || obs_reg.size() != exp_reg.size()) begin
            bad++;
            $display("FAIL rand_sizes[%0d]: got fb=%0d reg=%0d want fb=%0d reg=%0d",
                     f, obs_fa.size(), obs_reg.size(), exp_fa.size(), exp_reg.size());
         end else begin
            foreach (exp_fa[i]) begin
               total++;
               if (obs_fa[i] !== exp_fa[i] || obs_fd[i] !== exp_fd[i]) begin
                  bad++;
                  $display("FAIL rand_fb[%0d.%0d]: got (%h,%h) want (%h,%h)", f, i, obs_fa[i], obs_fd[i], exp_fa[i], exp_fd[i]);
               end
            end
            foreach (exp_reg[i]) begin
               total++;
               if (obs_reg[i] !== exp_reg[i]) begin
                  bad++;
                  $display("FAIL rand_reg[%0d]: got %h want %h", f, obs_reg[i], exp_reg[i]);
               end
            end
         end
         total++;
         if (frame_count !== 16'(exp_frames) || err_count !== 8'(exp_errs) || busy !== 1'b0) begin
            bad++;
            $display("FAIL rand_counters[%0d]: got fc=%0d ec=%0d busy=%b want fc=%0d ec=%0d busy=0",
                     f, frame_count, err_count, busy, exp_frames, exp_errs);
         end
      end
   endtask

   task automatic test_async_reset();
      clear_obs();
      fb_ready = 1'b0;
      tx_q = '{8'h01, 8'h00, 8'h40, 8'h5A, 8'h6B};
      drive_frame(0, 0);
      total++;
      if (fb_we !== 1'b1 || busy !== 1'b1) begin
         bad++;
         $display("FAIL arst_pre: got we=%b busy=%b want 1 1", fb_we, busy);
      end
      #2;
      rst = 1'b0;
      #1;
      total++;
      if ({fb_we, fb_addr, fb_data, reg_we, reg_addr, reg_data, busy, frame_count, err_count} !== '0) begin
         bad++;
         $display("FAIL arst_outputs: got we=%b a=%h d=%h rwe=%b ra=%h rd=%h busy=%b fc=%0d ec=%0d want all zero",
                  fb_we, fb_addr, fb_data, reg_we, reg_addr, reg_data, busy, frame_count, err_count);
      end
      @(posedge clk); #1;
      rst = 1'b1;
      fb_ready = 1'b1;
      exp_frames = 0;
      exp_errs = 0;
      clear_obs();
      tx_q = '{8'h01, 8'h00, 8'h50, 8'hC3};
      drive_frame(1, 1);
      exp_frames++;
      total++;
      if (obs_fa.size() != 1) begin
         bad++;
         $display("FAIL arst_reparse_count: got %0d want 1", obs_fa.size());
      end else if (obs_fa[0] !== 11'h050 || obs_fd[0] !== 8'hC3) begin
         bad++;
         $display("FAIL arst_reparse: got (%h,%h) want (050,c3)", obs_fa[0], obs_fd[0]);
      end
      total++;
      if (frame_count !== 16'(exp_frames) || err_count !== 8'(exp_errs)) begin
         bad++;
         $display("FAIL arst_counters: got fc=%0d ec=%0d want fc=%0d ec=%0d", frame_count, err_count, exp_frames, exp_errs);
      end
   endtask

   initial begin
      test_reset();
      test_fb_write();
      test_reg_write();
      test_wrap();
      test_backpressure();
      test_bad_opcode();
      test_restart_truncate();
      test_random();
      test_async_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/spi_frame_decoder.md
# spi_frame_decoder

Frame-level controller behind `spi_slave` in the display controller. Consumes the received byte stream (`data`/`valid`/`sot`/`eot`), parses each SPI transaction as a command frame, and sequences the writes that frame carries into the framebuffer write port or the control register port. Sits between `spi_slave` and the framebuffer and register file, and reports frame and error status.

## Interface
- `FB_ADDR_W`, 11, framebuffer word address width; bits of the 16-bit frame address above this are ignored.
- `clk`  in  1  system clock, shared with `spi_slave`.
- `rst`  in  1  asynchronous, active-low reset.
- `rx_data`  in  8  byte from `spi_slave.data`.
- `rx_valid`  in  1  single-cycle byte strobe.
- `rx_sot`  in  1  qualifies `rx_valid`: first byte of a transaction.
- `rx_eot`  in  1  single-cycle pulse after `ss` is released.
- `fb_addr`  out  FB_ADDR_W  framebuffer write address.
- `fb_data`  out  8  framebuffer write data.
- `fb_we`  out  1  write request; held until accepted.
- `fb_ready`  in  1  framebuffer accepts the write on a cycle where `fb_we && fb_ready`.
- `reg_addr`  out  8  control register address.
- `reg_data`  out  8  control register data.
- `reg_we`  out  1  single-cycle register write strobe; no backpressure.
- `busy`  out  1  high from the first byte of a frame until the frame ends and no write is pending.
- `frame_count`  out  16  completed non-error frames, wraps.
- `err_count`  out  8  error events, saturates at 0xFF.

## Operation
- Frame layout: byte0 = opcode, byte1 = addr_hi, byte2 = addr_lo, then payload bytes.
- Opcodes: 0x00 NOP (payload ignored); 0x01 FB_WRITE; 0x02 REG_WRITE; any other value is an error.
- States: IDLE, ADDR_HI, ADDR_LO, DATA, DISCARD.
- IDLE + `rx_valid` → latch opcode → ADDR_HI. An invalid opcode increments `err_count` and moves to DISCARD.
- ADDR_HI → ADDR_LO → DATA. Each transition consumes one byte.
- DATA, FB_WRITE: each byte drives `fb_data` = byte and `fb_addr` = current address. The address then increments modulo 2^FB_ADDR_W.
- DATA, REG_WRITE: the first byte pulses `reg_we` with `reg_addr` = addr_lo and `reg_data` = byte. Any further byte counts one error and moves to DISCARD.
- `rx_valid && rx_sot` in any state restarts parsing: the byte is treated as byte0. If the previous frame had not ended with `rx_eot`, that counts one error.
- `rx_eot` in any state → IDLE.
  - `frame_count` increments on `rx_eot` only when the frame reached DATA without any error, or was a complete NOP frame.
  - A frame truncated before DATA counts one error.
- Backpressure: the `fb_we` register is the only buffer.
  - A payload byte arriving while `fb_we && !fb_ready` is dropped and counts one error (overrun).
  - The address still increments, so later bytes stay address-aligned.
- `rx_eot` or restart while a write is pending: the pending write is kept and completes normally.
- Reset (any time, asynchronous): state IDLE; all outputs 0, including `fb_addr`, `fb_data`, `fb_we`, `reg_*`, `busy`, and both counters.

## Timing
- `fb_we`/`reg_we` assert on the cycle after the `rx_valid` that carried the payload byte (one-cycle latency).
- `fb_we` drops on the cycle after the accepting edge. `fb_addr`/`fb_data` are stable while `fb_we` is high.
- Back-to-back `rx_valid` on consecutive cycles must be handled at full rate when `fb_ready` is high.
- `rx_eot` and `rx_valid` in the same cycle: the byte is processed first, then the frame is closed.
- Counters update one cycle after the causing event. Simultaneous error events in one cycle count once.

## Structure
- Shared package `display_pkg`: opcode constants and the state enum.
- A single module with no sub-modules. Counters are inline with saturate and wrap logic.

## Test plan
- FB_WRITE 0x01,0x00,0x10,0xAA,0xBB with `fb_ready`=1 → writes (0x010,0xAA), (0x011,0xBB); `frame_count`=1; `err_count`=0.
- REG_WRITE 0x02,0x00,0x05,0x3C,0x77 → one `reg_we` pulse with addr 0x05 and data 0x3C; `err_count`=1; `frame_count` unchanged.
- FB_WRITE at addr 0x07FF with 2 payload bytes → writes to 0x7FF then 0x000 (wrap).
- `fb_ready`=0 held across two payload bytes 0x11,0x22 → `fb_we` stays high with data 0x11; 0x22 is dropped; `err_count`=1; the write of 0x11 completes when `fb_ready` rises.
- Opcode 0x7E followed by 3 bytes, then a new `rx_sot` frame NOP → `err_count`=1; the NOP frame completes; `frame_count`=1.
- `rst` asserted low mid-FB_WRITE → all outputs 0 immediately; the next `rx_sot` frame parses from byte0.
